// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM-subset pipeline control path:
// ALU opcodes, the per-stage control bundle and operand-forwarding selects.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;
  localparam logic [3:0] ALU_RSB = 4'b0100;
  localparam logic [3:0] ALU_RSC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MOV = 4'b1010;
  localparam logic [3:0] ALU_MVN = 4'b1011;
  localparam logic [3:0] ALU_BIC = 4'b1100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [3:0]       alu_op;
    logic             am;
    logic             s_enable;
    logic             load;
    logic             rf_enable;
    logic             size;
    logic             rw;
    logic             mem_enable;
    logic [REG_W-1:0] rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  // Youngest producer wins; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] pc_reg,
                                         input ctrl_bundle_t ex,
                                         input ctrl_bundle_t mem,
                                         input ctrl_bundle_t wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src == pc_reg) begin
      sel = FWD_RF;
    end else if (ex.rf_enable && (ex.rd == src)) begin
      sel = FWD_EX;
    end else if (mem.rf_enable && (mem.rd == src)) begin
      sel = FWD_MEM;
    end else if (wb.rf_enable && (wb.rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_ctrl_reg.sv
// One pipeline stage of control bundle: async clear, optional bubble insert.
module pipe_ctrl_reg
  import arm_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_bubble,
  input  ctrl_bundle_t i_d,
  output ctrl_bundle_t o_q
);

  ctrl_bundle_t r_q;

  // Stage register; a bubble overrides the incoming bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= BUBBLE;
    end else if (i_bubble) begin
      r_q <= BUBBLE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// Carries decoded control through EX/MEM/WB, stalls on load-use, flushes on
// taken branches, produces ALU forwarding selects and a saturating stall count.
module pipeline_ctrl_sequencer
  import arm_pipe_pkg::*;
#(
  parameter logic [REG_W-1:0] LINK_REG    = 4'd14,
  parameter logic [REG_W-1:0] PC_REG      = 4'd15,
  parameter int               STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_id_valid,
  input  logic [3:0]             i_id_alu_op,
  input  logic                   i_id_am,
  input  logic                   i_id_s_enable,
  input  logic                   i_id_load,
  input  logic                   i_id_rf_enable,
  input  logic                   i_id_size,
  input  logic                   i_id_rw,
  input  logic                   i_id_b,
  input  logic                   i_id_bl,
  input  logic                   i_id_cond_true,
  input  logic [REG_W-1:0]       i_id_rn,
  input  logic [REG_W-1:0]       i_id_rm,
  input  logic [REG_W-1:0]       i_id_rd,
  input  logic                   i_id_uses_rm,
  output logic                   o_pc_enable,
  output logic                   o_ifid_enable,
  output logic                   o_ifid_flush,
  output logic                   o_branch_taken,
  output logic [3:0]             o_ex_alu_op,
  output logic                   o_ex_am,
  output logic                   o_ex_s_enable,
  output logic                   o_mem_load,
  output logic                   o_mem_size,
  output logic                   o_mem_rw,
  output logic                   o_mem_enable,
  output logic                   o_wb_rf_enable,
  output logic [REG_W-1:0]       o_wb_rd,
  output logic [1:0]             o_fwd_a_sel,
  output logic [1:0]             o_fwd_b_sel,
  output logic                   o_stall,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  ctrl_bundle_t w_id_bundle;
  ctrl_bundle_t w_ex;
  ctrl_bundle_t w_mem;
  ctrl_bundle_t w_wb;
  logic         w_id_live;
  logic         w_stall;
  logic         w_branch;
  logic         w_unused;
  logic [STALL_CNT_W-1:0] r_stall_count;

  // ID bundle: a branch whose condition failed is dropped entirely, so a
  // not-taken BL never reaches the link write.
  always_comb begin
    w_id_live              = i_id_valid & ~((i_id_b | i_id_bl) & ~i_id_cond_true);
    w_id_bundle            = BUBBLE;
    w_id_bundle.alu_op     = i_id_alu_op;
    w_id_bundle.am         = i_id_am;
    w_id_bundle.s_enable   = i_id_s_enable;
    w_id_bundle.load       = i_id_load;
    w_id_bundle.size       = i_id_size;
    w_id_bundle.rw         = i_id_rw;
    w_id_bundle.mem_enable = i_id_load | i_id_rw;
    if (i_id_bl) begin
      w_id_bundle.rd        = LINK_REG;
      w_id_bundle.rf_enable = 1'b1;
    end else begin
      w_id_bundle.rd        = i_id_rd;
      w_id_bundle.rf_enable = i_id_rf_enable;
    end
  end

  // Hazard, branch and forwarding decisions from ID against in-flight stages.
  always_comb begin
    w_stall = i_id_valid & w_ex.load & w_ex.rf_enable &
              ((w_ex.rd == i_id_rn) | (i_id_uses_rm & (w_ex.rd == i_id_rm)));
    w_branch    = i_id_valid & (i_id_b | i_id_bl) & i_id_cond_true & ~w_stall;
    o_fwd_a_sel = fwd_sel(i_id_rn, PC_REG, w_ex, w_mem, w_wb);
    if (i_id_uses_rm) begin
      o_fwd_b_sel = fwd_sel(i_id_rm, PC_REG, w_ex, w_mem, w_wb);
    end else begin
      o_fwd_b_sel = FWD_RF;
    end
  end

  pipe_ctrl_reg u_ex_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (w_stall | ~w_id_live),
    .i_d      (w_id_bundle),
    .o_q      (w_ex)
  );

  pipe_ctrl_reg u_mem_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (1'b0),
    .i_d      (w_ex),
    .o_q      (w_mem)
  );

  pipe_ctrl_reg u_wb_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (1'b0),
    .i_d      (w_mem),
    .o_q      (w_wb)
  );

  // Bring-up stall counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= {STALL_CNT_W{1'b0}};
    end else if (w_stall && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign o_stall        = w_stall;
  assign o_pc_enable    = ~w_stall;
  assign o_ifid_enable  = ~w_stall;
  assign o_branch_taken = w_branch;
  assign o_ifid_flush   = w_branch;
  assign o_ex_alu_op    = w_ex.alu_op;
  assign o_ex_am        = w_ex.am;
  assign o_ex_s_enable  = w_ex.s_enable;
  assign o_mem_load     = w_mem.load;
  assign o_mem_size     = w_mem.size;
  assign o_mem_rw       = w_mem.rw;
  assign o_mem_enable   = w_mem.mem_enable;
  assign o_wb_rf_enable = w_wb.rf_enable;
  assign o_wb_rd        = w_wb.rd;
  assign o_stall_count  = r_stall_count;

  // Fields that travel with the bundle but are not consumed at that stage.
  assign w_unused = ^{w_mem.alu_op, w_mem.am, w_mem.s_enable,
                      w_wb.alu_op, w_wb.am, w_wb.s_enable, w_wb.load,
                      w_wb.size, w_wb.rw, w_wb.mem_enable};

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// Directed plus random checking of pipeline_ctrl_sequencer against an
// in-flight instruction list model.
module tb_pipeline_ctrl_sequencer;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [3:0] alu;
    logic       am, s, load, wr, size, rw;
    logic [3:0] rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_am, id_s_enable, id_load, id_rf_enable, id_size, id_rw;
  logic id_b, id_bl, id_cond_true, id_uses_rm;
  logic [3:0] id_alu_op, id_rn, id_rm, id_rd;
  logic o_pc_enable, o_ifid_enable, o_ifid_flush, o_branch_taken;
  logic [3:0] o_ex_alu_op, o_wb_rd;
  logic o_ex_am, o_ex_s_enable, o_mem_load, o_mem_size, o_mem_rw, o_mem_enable;
  logic o_wb_rf_enable, o_stall;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel;
  logic [CW-1:0] o_stall_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  ins_t m_pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  int   m_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl_sequencer #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_alu_op(id_alu_op), .i_id_am(id_am),
    .i_id_s_enable(id_s_enable), .i_id_load(id_load), .i_id_rf_enable(id_rf_enable),
    .i_id_size(id_size), .i_id_rw(id_rw), .i_id_b(id_b), .i_id_bl(id_bl),
    .i_id_cond_true(id_cond_true), .i_id_rn(id_rn), .i_id_rm(id_rm), .i_id_rd(id_rd),
    .i_id_uses_rm(id_uses_rm),
    .o_pc_enable(o_pc_enable), .o_ifid_enable(o_ifid_enable), .o_ifid_flush(o_ifid_flush),
    .o_branch_taken(o_branch_taken), .o_ex_alu_op(o_ex_alu_op), .o_ex_am(o_ex_am),
    .o_ex_s_enable(o_ex_s_enable), .o_mem_load(o_mem_load), .o_mem_size(o_mem_size),
    .o_mem_rw(o_mem_rw), .o_mem_enable(o_mem_enable), .o_wb_rf_enable(o_wb_rf_enable),
    .o_wb_rd(o_wb_rd), .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_stall(o_stall), .o_stall_count(o_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Nearest older writer of src, 1 = EX, 2 = MEM, 3 = WB; r15 never forwards.
  function automatic logic [1:0] exp_fwd(input logic [3:0] src);
    if (src == 4'd15) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (m_pipe[i].wr && m_pipe[i].rd == src) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_cnt = 0;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_alu_op = 4'd0; id_am = 1'b0; id_s_enable = 1'b0;
    id_load = 1'b0; id_rf_enable = 1'b0; id_size = 1'b0; id_rw = 1'b0;
    id_b = 1'b0; id_bl = 1'b0; id_cond_true = 1'b0;
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; id_uses_rm = 1'b0;
  endtask

  task automatic set_id(input logic [3:0] alu, input logic ld, input logic wr,
                        input logic b, input logic bl, input logic cond,
                        input logic [3:0] rn, input logic [3:0] rm,
                        input logic [3:0] rd, input logic um);
    set_idle();
    id_valid = 1'b1; id_alu_op = alu; id_load = ld; id_rf_enable = wr;
    id_b = b; id_bl = bl; id_cond_true = cond;
    id_rn = rn; id_rm = rm; id_rd = rd; id_uses_rm = um;
  endtask

  // One clock: check every output against the model, then retire one step.
  task automatic cycle();
    logic e_stall, e_br, kill;
    ins_t nxt;
    @(negedge clk);
    e_stall = id_valid && m_pipe[0].load && m_pipe[0].wr &&
              ((m_pipe[0].rd == id_rn) || (id_uses_rm && m_pipe[0].rd == id_rm));
    e_br = id_valid && (id_b || id_bl) && id_cond_true && !e_stall;
    chk("stall", o_stall, e_stall);
    chk("pc_enable", o_pc_enable, !e_stall);
    chk("ifid_enable", o_ifid_enable, !e_stall);
    chk("branch_taken", o_branch_taken, e_br);
    chk("ifid_flush", o_ifid_flush, e_br);
    chk("fwd_a", o_fwd_a_sel, exp_fwd(id_rn));
    chk("fwd_b", o_fwd_b_sel, id_uses_rm ? exp_fwd(id_rm) : 2'd0);
    chk("ex_bundle", {o_ex_alu_op, o_ex_am, o_ex_s_enable},
        {m_pipe[0].alu, m_pipe[0].am, m_pipe[0].s});
    chk("mem_bundle", {o_mem_load, o_mem_size, o_mem_rw, o_mem_enable},
        {m_pipe[1].load, m_pipe[1].size, m_pipe[1].rw, m_pipe[1].load | m_pipe[1].rw});
    chk("wb_bundle", {o_wb_rf_enable, o_wb_rd}, {m_pipe[2].wr, m_pipe[2].rd});
    chk("stall_count", o_stall_count, m_cnt);
    kill = e_stall || !id_valid || ((id_b || id_bl) && !id_cond_true);
    nxt = '0;
    if (!kill) begin
      nxt = '{alu: id_alu_op, am: id_am, s: id_s_enable, load: id_load,
              wr: id_rf_enable | id_bl, size: id_size, rw: id_rw,
              rd: id_bl ? 4'd14 : id_rd};
    end
    @(posedge clk);
    #1;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = nxt;
    if (e_stall && m_cnt < CNT_MAX) m_cnt++;
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    set_idle();
    model_clear();
    rst_n = 1'b0;
    #23;
    chk("rst_wb_rf_enable", o_wb_rf_enable, 1'b0);
    chk("rst_ex_alu_op", o_ex_alu_op, 4'd0);
    chk("rst_mem_enable", o_mem_enable, 1'b0);
    chk("rst_pc_enable", o_pc_enable, 1'b1);
    chk("rst_stall_count", o_stall_count, 0);
    chk("rst_fwd", {o_fwd_a_sel, o_fwd_b_sel}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD r1 then SUB r2,r1: EX forward; WB write three cycles after issue
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 4'd1, 1'b1);
    cycle();
    set_id(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 1'b0);
    #1 chk("add_sub_fwd_ex", o_fwd_a_sel, 2'b01);
    cycle();
    set_idle();
    cycle();
    chk("add_wb_en", o_wb_rf_enable, 1'b1);
    chk("add_wb_rd", o_wb_rd, 4'd1);
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0);
    cycle();
    set_idle();
    cycle();
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd6, 1'b0);
    #1 chk("nop_gap_fwd_mem", o_fwd_a_sel, 2'b10);
    cycle();

    // LDR r3 then ADD r4,r3: one stall, bubble in EX, then MEM forward
    set_id(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0);
    cycle();
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 1'b0);
    #1 chk("lu_stall", {o_stall, o_pc_enable}, 2'b10);
    cycle();
    chk("lu_bubble_mem_load", {o_ex_alu_op, o_mem_load}, 5'b0000_1);
    chk("lu_stall_gone", o_stall, 1'b0);
    chk("lu_fwd_mem", o_fwd_a_sel, 2'b10);
    chk("lu_count", o_stall_count, 1);
    cycle();

    // BL taken: flush for one cycle, link write to r14; then BL not taken
    set_id(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
    #1 chk("bl_flush", {o_branch_taken, o_ifid_flush}, 2'b11);
    cycle();
    set_idle();
    #1 chk("bl_flush_off", o_branch_taken, 1'b0);
    cycle();
    cycle();
    chk("bl_link", {o_wb_rf_enable, o_wb_rd}, {1'b1, 4'd14});
    set_id(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    #1 chk("bl_nt_noflush", o_ifid_flush, 1'b0);
    cycle();
    set_idle();
    cycle();
    cycle();
    chk("bl_nt_nowrite", o_wb_rf_enable, 1'b0);

    // Branch behind a load-use hazard: stall wins, branch next cycle
    set_id(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0);
    cycle();
    set_id(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0);
    #1 chk("br_stall_wins", {o_stall, o_branch_taken}, 2'b10);
    cycle();
    chk("br_after_stall", {o_stall, o_branch_taken}, 2'b01);
    cycle();

    // r15 as a destination never feeds the forwarding network
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 1'b0);
    cycle();
    set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd15, 4'd1, 1'b1);
    #1 chk("pc_no_fwd", {o_fwd_a_sel, o_fwd_b_sel}, 4'd0);
    cycle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      id_valid     = ($urandom_range(0, 9) != 0);
      id_alu_op    = 4'($urandom_range(0, 15));
      id_am        = 1'($urandom_range(0, 1));
      id_s_enable  = 1'($urandom_range(0, 1));
      id_load      = ($urandom_range(0, 3) == 0);
      id_rf_enable = 1'($urandom_range(0, 1));
      id_size      = 1'($urandom_range(0, 1));
      id_rw        = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: id_b = 1'b1;
        1: id_bl = 1'b1;
        default: ;
      endcase
      id_cond_true = 1'($urandom_range(0, 1));
      id_rn        = rreg();
      id_rm        = rreg();
      id_rd        = rreg();
      id_uses_rm   = 1'($urandom_range(0, 1));
      cycle();
    end

    // Load-use pairs until the counter pins at all-ones
    for (int n = 0; n < 300; n++) begin
      set_id(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0);
      cycle();
      set_id(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 1'b0);
      cycle();
      cycle();
    end
    chk("stall_count_sat", o_stall_count, CNT_MAX);

    // Reset in the middle of traffic clears WB immediately
    set_id(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0);
    cycle();
    set_idle();
    cycle();
    cycle();
    chk("pre_rst_wb", o_wb_rf_enable, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wb_rf_enable", o_wb_rf_enable, 1'b0);
    chk("midrst_stall_count", o_stall_count, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
